// File: rtl/hci_core_mem_resp_buffer.sv
// HCI core-to-memory bridge that tags requests with a rolling ID and buffers
// every memory response so that core-side lrdy backpressure never drops data.
module hci_core_mem_resp_buffer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned BW    = 8,
    parameter int unsigned UW    = 1,
    parameter int unsigned IW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       s_req_i,
    output logic                       s_gnt_o,
    input  logic [AW-1:0]              s_add_i,
    input  logic                       s_wen_i,
    input  logic [DW-1:0]              s_data_i,
    input  logic [DW/BW-1:0]           s_be_i,
    input  logic [UW-1:0]              s_user_i,
    input  logic                       s_lrdy_i,
    output logic [DW-1:0]              s_r_data_o,
    output logic                       s_r_valid_o,
    output logic                       s_r_opc_o,
    output logic [UW-1:0]              s_r_user_o,
    output logic                       m_req_o,
    input  logic                       m_gnt_i,
    output logic [AW-1:0]              m_add_o,
    output logic                       m_wen_o,
    output logic [DW-1:0]              m_data_o,
    output logic [DW/BW-1:0]           m_be_o,
    output logic [UW-1:0]              m_user_o,
    output logic [IW-1:0]              m_id_o,
    input  logic [DW-1:0]              m_r_data_i,
    input  logic [IW-1:0]              m_r_id_i,
    input  logic [UW-1:0]              m_r_user_i,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       err_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          opc;
    } entry_t;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end else begin
            return ptr + PW'(1'b1);
        end
    endfunction

    entry_t          fifo_r [DEPTH];
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic            inflight_r;
    logic [IW-1:0]   id_r;
    logic [IW-1:0]   exp_id_r;
    logic            err_r;

    logic [CW-1:0]   occ_s;
    logic            can_accept_s;
    logic            hs_s;
    logic            push_s;
    logic            pop_s;
    logic            mismatch_s;
    entry_t          head_s;

    // Credit counts only registered state, so a pop frees its slot one cycle later
    // and s_lrdy_i never reaches s_gnt_o combinationally.
    always_comb begin
        occ_s        = count_r + CW'(inflight_r);
        can_accept_s = (occ_s < CW'(DEPTH)) && !clear_i;
        hs_s         = s_req_i && m_gnt_i && can_accept_s;
        push_s       = inflight_r;
        mismatch_s   = (m_r_id_i != exp_id_r);
        pop_s        = (count_r != '0) && s_lrdy_i;
        head_s       = fifo_r[rptr_r];
    end

    assign m_req_o       = s_req_i && can_accept_s;
    assign s_gnt_o       = m_gnt_i && can_accept_s;
    assign m_add_o       = s_add_i;
    assign m_wen_o       = s_wen_i;
    assign m_data_o      = s_data_i;
    assign m_be_o        = s_be_i;
    assign m_user_o      = s_user_i;
    assign m_id_o        = id_r;
    assign s_r_valid_o   = (count_r != '0);
    assign s_r_data_o    = head_s.data;
    assign s_r_user_o    = head_s.user;
    assign s_r_opc_o     = head_s.opc;
    assign outstanding_o = occ_s;
    assign err_o         = err_r;

    // Response storage: written one cycle after each handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_r[i] <= '0;
            end
        end else if (push_s && !clear_i) begin
            fifo_r[wptr_r] <= '{data: m_r_data_i, user: m_r_user_i, opc: mismatch_s};
        end else begin
            fifo_r[wptr_r] <= fifo_r[wptr_r];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else if (clear_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Request tagging, in-flight tracking and sticky ID-mismatch flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_r <= 1'b0;
            id_r       <= '0;
            exp_id_r   <= '0;
            err_r      <= 1'b0;
        end else if (clear_i) begin
            inflight_r <= 1'b0;
            id_r       <= '0;
            exp_id_r   <= exp_id_r;
            err_r      <= 1'b0;
        end else begin
            inflight_r <= hs_s;
            if (hs_s) begin
                id_r     <= id_r + IW'(1'b1);
                exp_id_r <= id_r;
            end
            if (push_s && mismatch_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
